// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX stage bus (ID fields, forwarding sources, EX outputs, hazard status).
interface id_ex_if #(parameter int W = 32, parameter int RA = 5, parameter int CNT_W = 16);
    logic          id_valid;
    logic [W-1:0]  id_rs_val, id_rt_val, id_imm;
    logic [RA-1:0] id_rs, id_rt, id_rd;
    logic [3:0]    id_alu_op;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          flush;
    logic          exmem_reg_write;
    logic [RA-1:0] exmem_rd;
    logic [W-1:0]  exmem_result;
    logic          memwb_reg_write;
    logic [RA-1:0] memwb_rd;
    logic [W-1:0]  memwb_data;
    logic [W-1:0]  alu_i0, alu_i1, ex_store_data;
    logic [3:0]    alu_op;
    logic          ex_valid;
    logic [RA-1:0] ex_dst;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          hazard_stall;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_alu_op,
               id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_data,
        output alu_i0, alu_i1, ex_store_data, alu_op, ex_valid, ex_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall, stall_count
    );

    modport master (
        output id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_alu_op,
               id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_data,
        input  alu_i0, alu_i1, ex_store_data, alu_op, ex_valid, ex_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use stall and flush.
// ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; without it, RAW hazards stall instead.
module id_ex_stage #(
    parameter int W     = 32,
    parameter int RA    = 5,
    parameter int CNT_W = 16
) (
    input logic     clk,
    input logic     rst,
    id_ex_if.slave  io_bus
);
    logic [W-1:0]     r_rs_val, r_rt_val, r_imm;
    logic [RA-1:0]    r_rs, r_rt, r_dst;
    logic [3:0]       r_alu_op;
    logic             r_valid, r_alu_src, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
    logic [CNT_W-1:0] r_stall_count;
    logic [W-1:0]     w_a, w_b;
    logic             w_rt_used, w_load_use, w_stall, w_go;

    assign w_rt_used  = !io_bus.id_alu_src | io_bus.id_mem_write;
    assign w_load_use = io_bus.id_valid & r_valid & r_mem_read & (r_dst != '0) &
                        ((r_dst == io_bus.id_rs) | ((r_dst == io_bus.id_rt) & w_rt_used));

`ifdef ID_EX_FWD_EN
    assign w_a = (io_bus.exmem_reg_write && io_bus.exmem_rd != '0 && io_bus.exmem_rd == r_rs) ? io_bus.exmem_result :
                 (io_bus.memwb_reg_write && io_bus.memwb_rd != '0 && io_bus.memwb_rd == r_rs) ? io_bus.memwb_data :
                 r_rs_val;
    assign w_b = (io_bus.exmem_reg_write && io_bus.exmem_rd != '0 && io_bus.exmem_rd == r_rt) ? io_bus.exmem_result :
                 (io_bus.memwb_reg_write && io_bus.memwb_rd != '0 && io_bus.memwb_rd == r_rt) ? io_bus.memwb_data :
                 r_rt_val;
    assign w_stall = w_load_use;
`else
    logic w_rs_dep, w_rt_dep, w_unused;
    assign w_a = r_rs_val;
    assign w_b = r_rt_val;
    // MEM/WB needs no check: the register file writes before it reads
    assign w_rs_dep = (io_bus.id_rs != '0) &
                      ((r_valid & r_reg_write & (r_dst == io_bus.id_rs)) |
                       (io_bus.exmem_reg_write & (io_bus.exmem_rd == io_bus.id_rs)));
    assign w_rt_dep = (io_bus.id_rt != '0) & w_rt_used &
                      ((r_valid & r_reg_write & (r_dst == io_bus.id_rt)) |
                       (io_bus.exmem_reg_write & (io_bus.exmem_rd == io_bus.id_rt)));
    assign w_stall  = w_load_use | (io_bus.id_valid & (w_rs_dep | w_rt_dep));
    assign w_unused = ^{io_bus.exmem_result, io_bus.memwb_reg_write, io_bus.memwb_rd, io_bus.memwb_data};
`endif

    assign w_go = io_bus.id_valid & !io_bus.flush & !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_op      <= '0;
            r_rs_val      <= '0;
            r_rt_val      <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_dst         <= '0;
            r_stall_count <= '0;
        end else begin
            r_valid       <= w_go;
            r_reg_write   <= w_go & io_bus.id_reg_write;
            r_mem_read    <= w_go & io_bus.id_mem_read;
            r_mem_write   <= w_go & io_bus.id_mem_write;
            r_mem_to_reg  <= w_go & io_bus.id_mem_to_reg;
            r_alu_src     <= io_bus.id_alu_src;
            r_alu_op      <= io_bus.id_alu_op;
            r_rs_val      <= io_bus.id_rs_val;
            r_rt_val      <= io_bus.id_rt_val;
            r_imm         <= io_bus.id_imm;
            r_rs          <= io_bus.id_rs;
            r_rt          <= io_bus.id_rt;
            r_dst         <= io_bus.id_reg_dst ? io_bus.id_rd : io_bus.id_rt;
            if (w_stall && !io_bus.flush && !(&r_stall_count))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign io_bus.alu_i0        = w_a;
    assign io_bus.alu_i1        = r_alu_src ? r_imm : w_b;
    assign io_bus.ex_store_data = w_b;
    assign io_bus.alu_op        = r_alu_op;
    assign io_bus.ex_valid      = r_valid;
    assign io_bus.ex_dst        = r_dst;
    assign io_bus.ex_reg_write  = r_reg_write;
    assign io_bus.ex_mem_read   = r_mem_read;
    assign io_bus.ex_mem_write  = r_mem_write;
    assign io_bus.ex_mem_to_reg = r_mem_to_reg;
    assign io_bus.hazard_stall  = w_stall;
    assign io_bus.stall_count   = r_stall_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_if #(.W(32), .RA(5), .CNT_W(16)) b();
    id_ex_stage #(.W(32), .RA(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .io_bus(b));

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs, rt, dst;
        logic [3:0]  op;
        logic        alu_src, rw, mr, mw, m2r;
    } ex_t;

    ex_t         m;
    logic [15:0] m_cnt;
    ex_t         q[$];
    logic [15:0] qc[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsv, rtv, imm,
                          input logic [3:0] op, input logic src, dst, rw, mr, mw, m2r);
        b.id_valid = v; b.id_rs = rs; b.id_rt = rt; b.id_rd = rd;
        b.id_rs_val = rsv; b.id_rt_val = rtv; b.id_imm = imm; b.id_alu_op = op;
        b.id_alu_src = src; b.id_reg_dst = dst; b.id_reg_write = rw;
        b.id_mem_read = mr; b.id_mem_write = mw; b.id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
        b.exmem_reg_write = xw; b.exmem_rd = xrd; b.exmem_result = xres;
        b.memwb_reg_write = ww; b.memwb_rd = wrd; b.memwb_data = wdat;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
        if (b.exmem_reg_write && src != 0 && b.exmem_rd == src) return b.exmem_result;
        if (b.memwb_reg_write && src != 0 && b.memwb_rd == src) return b.memwb_data;
`endif
        return v;
    endfunction

    function automatic logic exp_stall();
        logic rt_used, s;
        rt_used = !b.id_alu_src || b.id_mem_write;
        s = b.id_valid && m.valid && m.mr && m.dst != 0 &&
            (m.dst == b.id_rs || (rt_used && m.dst == b.id_rt));
`ifndef ID_EX_FWD_EN
        if (b.id_valid && b.id_rs != 0 &&
            ((m.valid && m.rw && m.dst == b.id_rs) || (b.exmem_reg_write && b.exmem_rd == b.id_rs))) s = 1'b1;
        if (b.id_valid && rt_used && b.id_rt != 0 &&
            ((m.valid && m.rw && m.dst == b.id_rt) || (b.exmem_reg_write && b.exmem_rd == b.id_rt))) s = 1'b1;
`endif
        return s;
    endfunction

    // Called at the falling edge with inputs already set; returns at the next falling edge.
    task automatic step(input logic fl);
        ex_t n;
        logic st, go;
        logic [31:0] ea, eb;
        b.flush = fl;
        #1;
        st = exp_stall();
        chk("hazard_stall", b.hazard_stall, st);
        if (m.valid) begin
            ea = fwd(m.rs, m.rs_val);
            eb = fwd(m.rt, m.rt_val);
            chk("alu_i0", b.alu_i0, ea);
            chk("alu_i1", b.alu_i1, m.alu_src ? m.imm : eb);
            chk("ex_store_data", b.ex_store_data, eb);
        end
        go = b.id_valid && !fl && !st;
        n.valid = go;
        n.rs_val = b.id_rs_val; n.rt_val = b.id_rt_val; n.imm = b.id_imm;
        n.rs = b.id_rs; n.rt = b.id_rt; n.dst = b.id_reg_dst ? b.id_rd : b.id_rt;
        n.op = b.id_alu_op; n.alu_src = b.id_alu_src;
        n.rw = go && b.id_reg_write; n.mr = go && b.id_mem_read;
        n.mw = go && b.id_mem_write; n.m2r = go && b.id_mem_to_reg;
        q.push_back(n);
        qc.push_back((st && !fl && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt);
        @(posedge clk);
        #1;
        m = q.pop_front();
        m_cnt = qc.pop_front();
        chk("ex_valid", b.ex_valid, m.valid);
        chk("ex_reg_write", b.ex_reg_write, m.rw);
        chk("ex_mem_read", b.ex_mem_read, m.mr);
        chk("ex_mem_write", b.ex_mem_write, m.mw);
        chk("ex_mem_to_reg", b.ex_mem_to_reg, m.m2r);
        chk("stall_count", b.stall_count, m_cnt);
        if (m.valid) begin
            chk("ex_dst", b.ex_dst, m.dst);
            chk("alu_op", b.alu_op, m.op);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst ex_valid", b.ex_valid, 0);
        chk("rst ex_reg_write", b.ex_reg_write, 0);
        chk("rst ex_mem_read", b.ex_mem_read, 0);
        chk("rst stall_count", b.stall_count, 0);
        chk("rst hazard_stall", b.hazard_stall, 0);
        chk("rst alu_op", b.alu_op, 0);
        chk("rst alu_i0", b.alu_i0, 0);
        chk("rst alu_i1", b.alu_i1, 0);
        chk("rst ex_store_data", b.ex_store_data, 0);
    endtask

    initial begin
        b.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        m = '0;
        m_cnt = '0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        // add r3,r1,r2 then add r4,r3,r3 with r3 coming from EX/MEM
        set_id(1, 1, 2, 3, 5, 7, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        step(0);
        set_id(1, 3, 3, 4, 0, 0, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        step(0);
        set_fwd(1, 3, 12, 0, 0, 0);
        step(0);
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 3, 12, 1, 3, 99);
        step(0);
        set_fwd(0, 0, 0, 1, 3, 12);
        step(0);
        // load-use: lw r5 then add r6,r5,r2
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 5, 0, 5, 0, 4, 4'b0010, 1, 0, 1, 1, 0, 1);
        step(0);
        set_id(1, 5, 2, 6, 0, 7, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        step(0);
        set_fwd(0, 0, 0, 1, 5, 77);
        step(0);
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(0);
        // flush together with a load-use hazard
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 5, 0, 5, 0, 8, 4'b0010, 1, 0, 1, 1, 0, 1);
        step(0);
        set_id(1, 5, 5, 6, 0, 0, 0, 4'b0110, 0, 1, 1, 0, 0, 0);
        step(1);
        // writes to r0 are never forwarded and never stall
        set_id(1, 0, 0, 7, 0, 0, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
        set_fwd(1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
        step(0);
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(0);
        chk("r0 alu_i0", b.alu_i0, 0);
        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            step(1'($urandom_range(0, 7) == 0));
        end
        // mid-run asynchronous reset with a valid instruction in EX
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 2, 8, 3, 4, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        step(0);
        chk("pre-rst ex_valid", b.ex_valid, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_reset_state();
        m = '0;
        m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        step(0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
